// File: rtl/wdt_cmd_pkg.sv
// Shared definitions for the WDT command stream: opcodes, FSM states, frame lengths.
package wdt_cmd_pkg;

    typedef enum logic [1:0] {
        OPC_EN    = 2'b01,
        OPC_LIVE  = 2'b10,
        OPC_TOCNT = 2'b11
    } opc_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int unsigned TOCNT_W_DEFAULT = 32;

    localparam int unsigned LEN_LIVE  = 2;
    localparam int unsigned LEN_EN    = 3;
    localparam int unsigned LEN_TOCNT = TOCNT_W_DEFAULT + 2;

    // TOCNT frame length for a non-default payload width.
    function automatic int unsigned tocnt_frame_len(input int unsigned width);
        return width + 2;
    endfunction

endpackage

// File: rtl/wdt_cmd_serializer.sv
// Collects WDT enable/kick/timeout requests and serializes each as an
// opcode+payload frame, MSB first, into the 1-bit command FIFO.
module wdt_cmd_serializer
    import wdt_cmd_pkg::*;
#(
    parameter int unsigned TOCNT_W = TOCNT_W_DEFAULT
) (
    input  logic               w_clk,
    input  logic               w_rst,
    input  logic               en_req,
    input  logic               en_val,
    input  logic               live_req,
    input  logic               tocnt_req,
    input  logic [TOCNT_W-1:0] tocnt_val,
    input  logic               fifo_full,
    output logic               fifo_push,
    output logic               fifo_data,
    output logic               busy,
    output logic               frame_done
);

    localparam int unsigned FRAME_W = TOCNT_W + 2;
    localparam int unsigned CNT_W   = $clog2(TOCNT_W + 3);

    localparam logic [CNT_W-1:0] CNT_LIVE  = CNT_W'(LEN_LIVE);
    localparam logic [CNT_W-1:0] CNT_EN    = CNT_W'(LEN_EN);
    localparam logic [CNT_W-1:0] CNT_TOCNT = CNT_W'(tocnt_frame_len(TOCNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e               state_q;
    logic                 pend_live_q;
    logic                 pend_en_q;
    logic                 pend_tocnt_q;
    logic                 en_val_q;
    logic [TOCNT_W-1:0]   tocnt_val_q;
    logic [FRAME_W-1:0]   shreg_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 frame_done_q;

    logic                 grant_live;
    logic                 grant_en;
    logic                 grant_tocnt;
    logic [FRAME_W-1:0]   frame_sel;
    logic [CNT_W-1:0]     len_sel;

    // Fixed-priority grant (LIVE > EN > TOCNT) and the left-aligned frame it selects.
    always_comb begin
        grant_live  = 1'b0;
        grant_en    = 1'b0;
        grant_tocnt = 1'b0;
        frame_sel   = '0;
        len_sel     = '0;
        if (state_q == IDLE) begin
            if (pend_live_q) begin
                grant_live = 1'b1;
                frame_sel  = {OPC_LIVE, {TOCNT_W{1'b0}}};
                len_sel    = CNT_LIVE;
            end else if (pend_en_q) begin
                grant_en  = 1'b1;
                frame_sel = {OPC_EN, en_val_q, {(TOCNT_W - 1){1'b0}}};
                len_sel   = CNT_EN;
            end else if (pend_tocnt_q) begin
                grant_tocnt = 1'b1;
                frame_sel   = {OPC_TOCNT, tocnt_val_q};
                len_sel     = CNT_TOCNT;
            end
        end
    end

    // Pending flags, value capture and the IDLE/SEND frame shifter.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q      <= IDLE;
            pend_live_q  <= 1'b0;
            pend_en_q    <= 1'b0;
            pend_tocnt_q <= 1'b0;
            en_val_q     <= 1'b0;
            tocnt_val_q  <= '0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            // A new request in the grant cycle keeps the flag set for a later frame.
            pend_live_q  <= live_req  | (pend_live_q  & ~grant_live);
            pend_en_q    <= en_req    | (pend_en_q    & ~grant_en);
            pend_tocnt_q <= tocnt_req | (pend_tocnt_q & ~grant_tocnt);

            if (en_req) begin
                en_val_q <= en_val;
            end
            if (tocnt_req) begin
                tocnt_val_q <= tocnt_val;
            end

            case (state_q)
                IDLE: begin
                    if (grant_live | grant_en | grant_tocnt) begin
                        shreg_q <= frame_sel;
                        cnt_q   <= len_sel;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (!fifo_full) begin
                        shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                        cnt_q   <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_q      <= IDLE;
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Push follows fifo_full directly; fifo_full is registered inside the FIFO.
    always_comb begin
        fifo_push  = (state_q == SEND) & ~fifo_full;
        fifo_data  = shreg_q[FRAME_W-1];
        busy       = (state_q == SEND) | pend_live_q | pend_en_q | pend_tocnt_q;
        frame_done = frame_done_q;
    end

endmodule

// File: tb/tb_wdt_cmd_serializer.sv
// Scoreboard bench for wdt_cmd_serializer: stimulus queues expected frame bits,
// a negedge monitor pops and compares them on every push.
module tb_wdt_cmd_serializer;

    localparam int unsigned TW = 32;

    logic          w_clk     = 1'b0;
    logic          w_rst     = 1'b1;
    logic          en_req    = 1'b0;
    logic          en_val    = 1'b0;
    logic          live_req  = 1'b0;
    logic          tocnt_req = 1'b0;
    logic [TW-1:0] tocnt_val = '0;
    logic          fifo_full = 1'b0;
    logic          fifo_push;
    logic          fifo_data;
    logic          busy;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    bit exp_bits[$];
    int exp_len[$];
    int bits_left    = 0;
    bit done_due     = 1'b0;
    bit after_bubble = 1'b0;
    bit exp_b;
    int pushes       = 0;

    always #5 w_clk = ~w_clk;

    wdt_cmd_serializer #(
        .TOCNT_W (TW)
    ) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .en_req     (en_req),
        .en_val     (en_val),
        .live_req   (live_req),
        .tocnt_req  (tocnt_req),
        .tocnt_val  (tocnt_val),
        .fifo_full  (fifo_full),
        .fifo_push  (fifo_push),
        .fifo_data  (fifo_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_live();
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b0);
        exp_len.push_back(2);
    endtask

    task automatic exp_en(input bit v);
        exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b1);
        exp_bits.push_back(v);
        exp_len.push_back(3);
    endtask

    task automatic exp_tocnt(input logic [TW-1:0] v);
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b1);
        for (int i = TW - 1; i >= 0; i--) begin
            exp_bits.push_back(v[i]);
        end
        exp_len.push_back(TW + 2);
    endtask

    // Inputs change just after the active edge; outputs are sampled at the falling edge.
    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge w_clk);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((busy || exp_len.size() > 0 || bits_left > 0) && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
        end
        chk({name, "_queue_empty"}, exp_bits.size(), 0);
        mid();
        chk({name, "_busy_idle"}, busy, 0);
    endtask

    // Monitor: pops expected bits on each push, tracks frame_done and the IDLE bubble.
    always @(negedge w_clk) begin
        if (w_rst) begin
            exp_bits.delete();
            exp_len.delete();
            bits_left    = 0;
            done_due     = 1'b0;
            after_bubble = 1'b0;
        end else begin
            chk("frame_done", frame_done, done_due);
            if (after_bubble && exp_len.size() > 0 && !fifo_full) begin
                chk("bubble_next_push", fifo_push, 1);
            end
            after_bubble = 1'b0;
            if (done_due) begin
                chk("bubble_push", fifo_push, 0);
                after_bubble = 1'b1;
            end
            done_due = 1'b0;
            if (fifo_push) begin
                pushes++;
                if (bits_left == 0) begin
                    if (exp_len.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_push: push=1 data=%0b, expected no push",
                                 fifo_data);
                    end else begin
                        bits_left = exp_len.pop_front();
                    end
                end
                if (bits_left > 0) begin
                    exp_b = exp_bits.pop_front();
                    chk("fifo_data", fifo_data, exp_b);
                    bits_left--;
                    if (bits_left == 0) begin
                        done_due = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [TW+1:0] fr;
        int p0;

        // Reset state, while held and after release.
        repeat (3) step();
        mid();
        chk("rst_push", fifo_push, 0);
        chk("rst_data", fifo_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        step();
        w_rst = 1'b0;
        mid();
        chk("post_rst_push", fifo_push, 0);
        chk("post_rst_busy", busy, 0);

        // LIVE frame latency: pushes at N+2..N+3, frame_done at N+4.
        step();
        live_req = 1'b1;
        exp_live();
        mid();
        chk("live_n_busy", busy, 0);
        step();
        live_req = 1'b0;
        mid();
        chk("live_n1_busy", busy, 1);
        chk("live_n1_push", fifo_push, 0);
        step();
        mid();
        chk("live_n2_push", fifo_push, 1);
        chk("live_n2_busy", busy, 1);
        step();
        mid();
        chk("live_n3_push", fifo_push, 1);
        chk("live_n3_busy", busy, 1);
        step();
        mid();
        chk("live_n4_done", frame_done, 1);
        chk("live_n4_busy", busy, 0);
        chk("live_n4_push", fifo_push, 0);
        drain("live", 20);

        // EN frame carrying 1.
        step();
        en_req = 1'b1;
        en_val = 1'b1;
        exp_en(1'b1);
        step();
        en_req = 1'b0;
        en_val = 1'b0;
        drain("en", 20);

        // TOCNT frame 0x8000_0001.
        step();
        tocnt_req = 1'b1;
        tocnt_val = 32'h8000_0001;
        exp_tocnt(32'h8000_0001);
        step();
        tocnt_req = 1'b0;
        tocnt_val = '0;
        drain("tocnt", 60);

        // Simultaneous requests: LIVE, EN(0), TOCNT(5) in priority order.
        p0 = pushes;
        step();
        live_req  = 1'b1;
        en_req    = 1'b1;
        en_val    = 1'b0;
        tocnt_req = 1'b1;
        tocnt_val = 32'h0000_0005;
        exp_live();
        exp_en(1'b0);
        exp_tocnt(32'h0000_0005);
        step();
        live_req  = 1'b0;
        en_req    = 1'b0;
        tocnt_req = 1'b0;
        tocnt_val = '0;
        drain("multi", 100);
        chk("multi_push_count", pushes - p0, 39);

        // EN coalescing during a TOCNT frame: values 1,0,1 give one EN frame of 1.
        step();
        tocnt_req = 1'b1;
        tocnt_val = 32'h1234_5678;
        exp_tocnt(32'h1234_5678);
        step();
        tocnt_req = 1'b0;
        repeat (4) step();
        en_req = 1'b1;
        en_val = 1'b1;
        exp_en(1'b1);
        step();
        en_val = 1'b0;
        step();
        en_val = 1'b1;
        step();
        en_req = 1'b0;
        en_val = 1'b0;
        drain("coalesce", 80);

        // Stall for 5 cycles before bit 7 of a TOCNT frame.
        fr = {2'b11, 32'hA5A5_5A5A};
        step();
        tocnt_req = 1'b1;
        tocnt_val = 32'hA5A5_5A5A;
        exp_tocnt(32'hA5A5_5A5A);
        step();
        tocnt_req = 1'b0;
        repeat (8) step();
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("stall_push", fifo_push, 0);
            chk("stall_data", fifo_data, fr[TW+1-7]);
            chk("stall_busy", busy, 1);
            step();
        end
        fifo_full = 1'b0;
        drain("stall", 80);

        // Reset at bit 10 of a TOCNT frame, then a clean LIVE frame.
        step();
        tocnt_req = 1'b1;
        tocnt_val = 32'h8000_0001;
        exp_tocnt(32'h8000_0001);
        step();
        tocnt_req = 1'b0;
        repeat (11) step();
        w_rst = 1'b1;
        mid();
        chk("rst_mid_push_before", fifo_push, 1);
        step();
        w_rst = 1'b0;
        mid();
        chk("rst_mid_push", fifo_push, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", frame_done, 0);
        p0 = pushes;
        step();
        live_req = 1'b1;
        exp_live();
        step();
        live_req = 1'b0;
        drain("rst_live", 20);
        chk("rst_live_push_count", pushes - p0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
